// File: rtl/seq_detect_cfg.sv
// Runtime-programmable serial pattern detector: configurable pattern, length and
// overlap mode, valid-qualified input, registered match pulse and saturating count.
module seq_detect_cfg #(
    parameter int                  MAX_LEN     = 8,
    parameter int                  LEN_W       = 4,
    parameter int                  CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  DEF_PATTERN = 8'b0000_1011,
    parameter logic [LEN_W-1:0]    DEF_LEN     = 4'd4,
    parameter logic                DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               data_valid,
    input  logic               data_in,
    input  logic               cnt_clr,
    output logic               detector,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_clamped;
    logic               shift_en;
    logic               match;
    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [LEN_W-1:0]   len_d;
    logic               armed_d;

    // Stream qualification: data_in is consumed only on cycles with data_valid=1;
    // there is no back-pressure. A cfg_load in the same cycle discards the bit.
    assign shift_en    = data_valid && !cfg_load;
    assign hist_shift  = {hist[MAX_LEN-2:0], data_in};
    assign fill_inc    = (fill >= LEN_MAX) ? fill : fill + LEN_W'(1);
    assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    // Only the low len_r bits of history and pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_r));
        end
    end

    assign match = shift_en && (len_r != '0) && (fill_inc >= len_r) &&
                   (((hist_shift ^ pat_r) & mask) == '0);

    always_comb begin
        hist_d = hist;
        fill_d = fill;
        len_d  = len_r;
        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
            len_d  = len_clamped;
        end else if (shift_en) begin
            hist_d = hist_shift;
            fill_d = (match && !ovl_r) ? '0 : fill_inc;
        end
        armed_d = (len_d != '0) && (fill_d >= len_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r       <= DEF_PATTERN;
            len_r       <= DEF_LEN;
            ovl_r       <= DEF_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            detector    <= 1'b0;
            armed       <= 1'b0;
            match_count <= '0;
        end else begin
            if (cfg_load) begin
                pat_r <= cfg_pattern;
                len_r <= len_clamped;
                ovl_r <= cfg_overlap;
            end
            hist     <= hist_d;
            fill     <= fill_d;
            detector <= match;
            armed    <= armed_d;
            // A clear coinciding with a match leaves that match counted.
            if (match) begin
                if (cnt_clr) begin
                    match_count <= CNT_W'(1);
                end else if (match_count != '1) begin
                    match_count <= match_count + CNT_W'(1);
                end
            end else if (cnt_clr) begin
                match_count <= '0;
            end
        end
    end

endmodule
